// File: rtl/result_reader_pkg.sv
// Shared constants and types for the result RAM readout path.
// The RAM geometry values must match the ones used by multi_solver.
package result_reader_pkg;

  localparam int RAM_DEPTH   = 1024;
  localparam int RAM_AW      = 10;
  localparam int SOLVER_ID_W = 6;
  localparam int PIX_DW      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_OUTPUT
  } state_t;

  // Highest word address any solver RAM is read at for a WIDTH x HEIGHT frame.
  function automatic int last_addr(input int n_solvers, input int width, input int height);
    int words;
    words = (width * height + n_solvers - 1) / n_solvers;
    if (words > RAM_DEPTH) words = RAM_DEPTH;
    if (words < 1) words = 1;
    return words - 1;
  endfunction

endpackage

// File: rtl/result_reader_interleave_counter.sv
// Walks the (solver id, RAM address) pair that pixel index p maps to:
// the id cycles 0..N-1, and the address steps each time the id wraps.
module interleave_counter
  import result_reader_pkg::*;
#(
  parameter int NUM_SOLVERS = 1,
  parameter int ADDR_MAX    = RAM_DEPTH - 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_advance,
  output logic [SOLVER_ID_W-1:0] o_solver_id,
  output logic [RAM_AW-1:0]      o_addr
);

  localparam logic [SOLVER_ID_W-1:0] LAST_ID   = SOLVER_ID_W'(NUM_SOLVERS - 1);
  localparam logic [RAM_AW-1:0]      LAST_ADDR = RAM_AW'(ADDR_MAX);

  logic [SOLVER_ID_W-1:0] r_solver_id;
  logic [RAM_AW-1:0]      r_addr;
  logic                   w_id_wrap;

  assign w_id_wrap = (r_solver_id == LAST_ID);

  // The address saturates at the last used word so it can never run past the frame.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_solver_id <= '0;
      r_addr      <= '0;
    end else if (i_advance) begin
      if (w_id_wrap) begin
        r_solver_id <= '0;
        if (r_addr != LAST_ADDR) begin
          r_addr <= r_addr + 1'b1;
        end
      end else begin
        r_solver_id <= r_solver_id + 1'b1;
      end
    end
  end

  assign o_solver_id = r_solver_id;
  assign o_addr      = r_addr;

endmodule

// File: rtl/result_reader.sv
// Drains multi_solver's per-solver result RAMs in raster order and presents
// each pixel with its x/y position on a valid/ready stream.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int NUM_SOLVERS = 1,
  parameter int WIDTH       = 32,
  parameter int HEIGHT      = 32,
  parameter int X_W         = 10,
  parameter int Y_W         = 10
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  output logic [SOLVER_ID_W-1:0]   o_rd_solver_id,
  output logic [RAM_AW-1:0]        o_rd_addr,
  input  logic signed [PIX_DW-1:0] i_rd_data_in,
  output logic signed [PIX_DW-1:0] o_pix_data,
  output logic [X_W-1:0]           o_pix_x,
  output logic [Y_W-1:0]           o_pix_y,
  output logic                     o_pix_valid,
  input  logic                     i_pix_ready,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int             ADDR_MAX = last_addr(NUM_SOLVERS, WIDTH, HEIGHT);
  localparam logic [X_W-1:0] LAST_X   = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] LAST_Y   = Y_W'(HEIGHT - 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [X_W-1:0]           r_x;
  logic [Y_W-1:0]           r_y;
  logic signed [PIX_DW-1:0] r_pix_data;
  logic                     w_accept;
  logic                     w_last_pixel;
  logic                     w_frame_end;
  logic                     w_advance;

  assign w_accept     = (r_state == ST_OUTPUT) && i_pix_ready;
  assign w_last_pixel = (r_x == LAST_X) && (r_y == LAST_Y);
  assign w_frame_end  = w_accept && w_last_pixel;
  assign w_advance    = w_accept && !w_last_pixel;

  // Counters only move on acceptance, so id/addr stay put through issue and capture.
  interleave_counter #(
    .NUM_SOLVERS (NUM_SOLVERS),
    .ADDR_MAX    (ADDR_MAX)
  ) u_interleave_counter (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (w_frame_end),
    .i_advance   (w_advance),
    .o_solver_id (o_rd_solver_id),
    .o_addr      (o_rd_addr)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_next_state = ST_ISSUE;
      ST_ISSUE:   w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_OUTPUT;
      ST_OUTPUT: begin
        if (w_frame_end) begin
          w_next_state = ST_IDLE;
        end else if (w_advance) begin
          w_next_state = ST_ISSUE;
        end
      end
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_pix_valid  = (r_state == ST_OUTPUT);
    o_busy       = (r_state != ST_IDLE);
    o_frame_done = w_frame_end;
  end

  // The RAM word is valid during CAPTURE, one cycle after the address was issued.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pix_data <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_pix_data <= i_rd_data_in;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || w_frame_end) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_advance) begin
      if (r_x == LAST_X) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_pix_data = r_pix_data;
  assign o_pix_x    = r_x;
  assign o_pix_y    = r_y;

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: two instances (4 solvers 4x4, 1 solver 8x2) fed by
// modelled solver RAMs, with the pixel stream compared to a raster-order reference.
module tb_result_reader;
  import result_reader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 4 solvers, 4x4 frame
  logic                     resetA, startA, readyA;
  logic [SOLVER_ID_W-1:0]   rdIdA;
  logic [RAM_AW-1:0]        rdAddrA;
  logic signed [PIX_DW-1:0] rdDataA, pixDataA;
  logic [9:0]               pixXA, pixYA;
  logic                     validA, busyA, doneA;

  // Instance B: 1 solver, 8x2 frame
  logic                     resetB, startB, readyB;
  logic [SOLVER_ID_W-1:0]   rdIdB;
  logic [RAM_AW-1:0]        rdAddrB;
  logic signed [PIX_DW-1:0] rdDataB, pixDataB;
  logic [9:0]               pixXB, pixYB;
  logic                     validB, busyB, doneB;

  logic [7:0] memA [4][16];
  logic [7:0] memB [16];
  logic [7:0] qA   [4];
  logic [7:0] qB;

  // Solver RAMs: registered read, output muxed by the current solver id.
  always @(posedge clk) begin
    for (int s = 0; s < 4; s++) qA[s] <= memA[s][rdAddrA[3:0]];
    qB <= memB[rdAddrB[3:0]];
  end
  assign rdDataA = qA[rdIdA[1:0]];
  assign rdDataB = qB;

  result_reader #(.NUM_SOLVERS(4), .WIDTH(4), .HEIGHT(4), .X_W(10), .Y_W(10)) dutA (
    .i_clock(clk), .i_reset(resetA), .i_start(startA),
    .o_rd_solver_id(rdIdA), .o_rd_addr(rdAddrA), .i_rd_data_in(rdDataA),
    .o_pix_data(pixDataA), .o_pix_x(pixXA), .o_pix_y(pixYA),
    .o_pix_valid(validA), .i_pix_ready(readyA), .o_busy(busyA), .o_frame_done(doneA)
  );

  result_reader #(.NUM_SOLVERS(1), .WIDTH(8), .HEIGHT(2), .X_W(10), .Y_W(10)) dutB (
    .i_clock(clk), .i_reset(resetB), .i_start(startB),
    .o_rd_solver_id(rdIdB), .o_rd_addr(rdAddrB), .i_rd_data_in(rdDataB),
    .o_pix_data(pixDataB), .o_pix_x(pixXB), .o_pix_y(pixYB),
    .o_pix_valid(validB), .i_pix_ready(readyB), .o_busy(busyB), .o_frame_done(doneB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sample(input int which, output logic v, output logic b, output logic d,
                        output logic [31:0] data, output logic [31:0] x, output logic [31:0] y,
                        output logic [31:0] id, output logic [31:0] addr);
    if (which == 0) begin
      v = validA; b = busyA; d = doneA;
      data = {24'b0, pixDataA}; x = {22'b0, pixXA}; y = {22'b0, pixYA};
      id = {26'b0, rdIdA}; addr = {22'b0, rdAddrA};
    end else begin
      v = validB; b = busyB; d = doneB;
      data = {24'b0, pixDataB}; x = {22'b0, pixXB}; y = {22'b0, pixYB};
      id = {26'b0, rdIdB}; addr = {22'b0, rdAddrB};
    end
  endtask

  task automatic setStart(input int which, input logic val);
    if (which == 0) startA = val; else startB = val;
  endtask

  task automatic setReady(input int which, input logic val);
    if (which == 0) readyA = val; else readyB = val;
  endtask

  task automatic setReset(input int which, input logic val);
    if (which == 0) resetA = val; else resetB = val;
  endtask

  // Reference: pixel p lives in solver p % N at word p / N and sits at (p % W, p / W).
  function automatic logic [7:0] expData(input int which, input int p);
    if (which == 0) return memA[p % 4][p / 4];
    return memB[p];
  endfunction

  task automatic checkAllZero(input int which, input string tag);
    logic v, b, d;
    logic [31:0] data, x, y, id, addr;
    sample(which, v, b, d, data, x, y, id, addr);
    checkOutput({tag, ".valid"}, {31'b0, v}, 0);
    checkOutput({tag, ".busy"}, {31'b0, b}, 0);
    checkOutput({tag, ".done"}, {31'b0, d}, 0);
    checkOutput({tag, ".x"}, x, 0);
    checkOutput({tag, ".y"}, y, 0);
    checkOutput({tag, ".id"}, id, 0);
    checkOutput({tag, ".addr"}, addr, 0);
  endtask

  // Runs one frame: random or forced ready, optional stall, stray start, or mid-frame reset.
  task automatic applyStimulus(input int which, input int readyPct, input int stallPixel,
                               input int stallLen, input int busyStartPixel, input int resetPixel);
    int total, w, n, p, cyc, prevCyc, stallCnt;
    bit held, extraStart, rdy;
    logic v, b, d;
    logic [31:0] data, x, y, id, addr;
    logic [31:0] hData, hX, hY, hId, hAddr;
    logic [7:0] e;
    total = 16;
    w = (which == 0) ? 4 : 8;
    n = (which == 0) ? 4 : 1;
    p = 0; cyc = 0; prevCyc = 0; stallCnt = 0; held = 0; extraStart = 0;
    hData = 0; hX = 0; hY = 0; hId = 0; hAddr = 0;
    @(negedge clk);
    setStart(which, 1'b1);
    while (p < total && cyc < 400) begin
      @(negedge clk);
      cyc++;
      setStart(which, 1'b0);
      sample(which, v, b, d, data, x, y, id, addr);
      if (v && p == resetPixel) begin
        setReady(which, 1'b0);
        setReset(which, 1'b1);
        @(negedge clk);
        setReset(which, 1'b0);
        checkAllZero(which, "midReset");
        return;
      end
      if (b && p == busyStartPixel && !extraStart) begin
        setStart(which, 1'b1);
        extraStart = 1;
      end
      if (v && p == stallPixel && stallCnt < stallLen) begin
        rdy = 0;
        stallCnt++;
      end else begin
        rdy = ($urandom_range(99) < readyPct);
      end
      setReady(which, rdy);
      #1;
      sample(which, v, b, d, data, x, y, id, addr);
      if (v) begin
        if (held) begin
          checkOutput("hold.data", data, hData);
          checkOutput("hold.x", x, hX);
          checkOutput("hold.y", y, hY);
          checkOutput("hold.id", id, hId);
          checkOutput("hold.addr", addr, hAddr);
        end
        if (rdy) begin
          e = expData(which, p);
          checkOutput("pix.data", data, {24'b0, e});
          checkOutput("pix.x", x, p % w);
          checkOutput("pix.y", y, p / w);
          checkOutput("rd.id", id, p % n);
          checkOutput("rd.addr", addr, p / n);
          checkOutput("frameDone", {31'b0, d}, (p == total - 1) ? 1 : 0);
          if (e == 8'h80) checkOutput("signedPass", 32'($signed(data[7:0])), -32'sd128);
          if (readyPct == 100 && stallLen == 0)
            checkOutput("spacing", cyc - prevCyc, 3);
          prevCyc = cyc;
          p++;
          held = 0;
        end else begin
          held = 1;
          hData = data; hX = x; hY = y; hId = id; hAddr = addr;
        end
      end else begin
        checkOutput("noDoneIdle", {31'b0, d}, 0);
      end
    end
    checkOutput("pixelCount", p, total);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      setReady(which, 1'b1);
      #1;
      sample(which, v, b, d, data, x, y, id, addr);
      checkOutput("postFrame.valid", {31'b0, v}, 0);
      checkOutput("postFrame.busy", {31'b0, b}, 0);
    end
    setReady(which, 1'b0);
  endtask

  initial begin
    resetA = 1'b1; resetB = 1'b1;
    startA = 1'b0; startB = 1'b0;
    readyA = 1'b0; readyB = 1'b0;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++) memA[s][a] = 8'(16 * s + a);
    for (int a = 0; a < 16; a++) memB[a] = 8'($urandom);
    repeat (3) @(negedge clk);
    checkAllZero(0, "resetA");
    checkAllZero(1, "resetB");
    checkOutput("resetA.data", {24'b0, pixDataA}, 0);
    resetA = 1'b0; resetB = 1'b0;

    $display("[TB] preload pattern, ready held high");
    applyStimulus(0, 100, -1, 0, -1, -1);

    $display("[TB] backpressure on pixel 6");
    applyStimulus(0, 100, 6, 5, -1, -1);

    $display("[TB] random RAM, reset at pixel 9");
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++) memA[s][a] = 8'($urandom);
    applyStimulus(0, 70, -1, 0, -1, 9);

    $display("[TB] restart, signed word, start while busy at pixel 3");
    memA[1][2] = 8'h80;
    applyStimulus(0, 70, -1, 0, 3, -1);

    $display("[TB] single solver 8x2 frame");
    applyStimulus(1, 60, -1, 0, -1, -1);
    applyStimulus(1, 100, -1, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
